// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder: datapath widths, default depth
// and the controller state encoding.
package mac_pkg;
  localparam int FP_W          = 16;
  localparam int DEPTH_DEFAULT = 8;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    RUN,
    DRAIN,
    RESP
  } state_t;
endpackage

// File: rtl/mac_operand_buf.sv
// Operand pair storage: DEPTH x 32-bit register file written in arrival order
// and read back sequentially through a registered read port.
module mac_operand_buf
  import mac_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2*FP_W-1:0] wr_data,
  input  logic              clear,
  input  logic              rd_start,
  input  logic              rd_adv,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  rd_idx,
  output logic [2*FP_W-1:0] rd_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2*FP_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  wr_idx_reg;
  logic [CNT_W-1:0]  rd_idx_reg;
  logic [CNT_W-1:0]  rd_idx_next;
  logic [2*FP_W-1:0] rd_data_reg;

  // The read address runs one step ahead so rd_data lines up with rd_idx.
  always_comb begin
    rd_idx_next = rd_idx_reg;
    if (rd_start) begin
      rd_idx_next = '0;
    end else if (rd_adv) begin
      rd_idx_next = rd_idx_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx_reg < CNT_W'(DEPTH))) begin
      mem[wr_idx_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_reg  <= '0;
      rd_idx_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      if (clear) begin
        wr_idx_reg <= '0;
      end else if (wr_en) begin
        wr_idx_reg <= wr_idx_reg + CNT_W'(1);
      end
      rd_idx_reg <= rd_idx_next;
      if (rd_idx_next < CNT_W'(DEPTH)) begin
        rd_data_reg <= mem[rd_idx_next[AW-1:0]];
      end
    end
  end

  assign count   = wr_idx_reg;
  assign rd_idx  = rd_idx_reg;
  assign rd_data = rd_data_reg;
endmodule

// File: rtl/mac_operand_feeder.sv
// Collects a burst of FP16 operand pairs, then replays them into an external
// MAC (clear, count enables, drain) and holds the captured result for a consumer.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             mac_clear,
  output logic             mac_enable,
  output logic [FP_W-1:0]  mac_a,
  output logic [FP_W-1:0]  mac_b,
  input  logic [FP_W-1:0]  mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FP_W-1:0]  res_data,
  output logic [CNT_W-1:0] res_count
);
  state_t            state_reg, state_next;
  logic [7:0]        lat_reg, lat_next;
  logic              wr_en, buf_clear, rd_start, rd_adv, capture, accept;
  logic [CNT_W-1:0]  count, rd_idx, count_after;
  logic [2*FP_W-1:0] rd_data;
  logic              in_ready_reg, mac_clear_reg, mac_enable_reg, res_valid_reg;
  logic [FP_W-1:0]   res_data_reg;
  logic [CNT_W-1:0]  res_count_reg;

  assign accept = in_valid && in_ready_reg;

  mac_operand_buf #(.DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  ({in_a, in_b}),
    .clear    (buf_clear),
    .rd_start (rd_start),
    .rd_adv   (rd_adv),
    .count    (count),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    wr_en      = 1'b0;
    buf_clear  = 1'b0;
    rd_start   = 1'b0;
    rd_adv     = 1'b0;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE, LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (in_last || (count == CNT_W'(DEPTH - 1))) state_next = CLEAR;
          else                                         state_next = LOAD;
        end
      end
      CLEAR: begin
        rd_start   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        rd_adv = 1'b1;
        if (rd_idx == count - CNT_W'(1)) begin
          state_next = DRAIN;
          lat_next   = '0;
        end
      end
      DRAIN: begin
        lat_next = lat_reg + 8'd1;
        if (lat_reg == 8'(MAC_LAT - 1)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          buf_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    count_after = buf_clear ? '0 : (wr_en ? count + CNT_W'(1) : count);
  end

  // Every output is registered from the next-state view, so none depends combinationally on an input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      lat_reg        <= '0;
      in_ready_reg   <= 1'b0;
      mac_clear_reg  <= 1'b0;
      mac_enable_reg <= 1'b0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= '0;
      res_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      lat_reg        <= lat_next;
      in_ready_reg   <= ((state_next == IDLE) || (state_next == LOAD)) &&
                        (count_after < CNT_W'(DEPTH));
      mac_clear_reg  <= (state_next == CLEAR);
      mac_enable_reg <= (state_next == RUN);
      res_valid_reg  <= (state_next == RESP);
      if (capture) begin
        res_data_reg  <= mac_result;
        res_count_reg <= count;
      end
    end
  end

  assign in_ready   = in_ready_reg;
  assign mac_clear  = mac_clear_reg;
  assign mac_enable = mac_enable_reg;
  assign mac_a      = mac_enable_reg ? rd_data[2*FP_W-1:FP_W] : '0;
  assign mac_b      = mac_enable_reg ? rd_data[FP_W-1:0] : '0;
  assign res_valid  = res_valid_reg;
  assign res_data   = res_data_reg;
  assign res_count  = res_count_reg;
endmodule
